cabac_mvd_top_ctrl: RTL
=======================

Name: cabac_mvd_top_ctrl

Overview:
- Sequences the CABAC top-row MVD line buffer: one 18-bit entry per macroblock column, held in the existing two-port RF wrapper.
- At each macroblock start it fetches the top neighbour's MVD pair for the CABAC context-selection logic.
- At macroblock end it writes back the current macroblock's bottom-row MVD pair.
- Handles first-row unavailability, read/write same-address forwarding and out-of-range column indices.

Parameters:
- ADDR_W, 8, line-buffer address width (equals `MEM_TOP_DEPTH`).
- DATA_W, 18, entry width; equals 2*(`FMV_WIDTH`+1), holding {mvd_y, mvd_x}.
- MB_X_TOTAL, 120, number of macroblock columns; valid column indices are 0..MB_X_TOTAL-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mb_start_i  in  1  one-cycle pulse: new macroblock begins.
- mb_x_i  in  ADDR_W  macroblock column; sampled on mb_start_i.
- mb_y_i  in  8  macroblock row; sampled on mb_start_i.
- top_vld_o  out  1  top_mvd_o is valid for the current macroblock.
- top_mvd_o  out  DATA_W  top-neighbour MVD pair; 0 when unavailable.
- busy_o  out  1  fetch in progress; mb_start_i must not be asserted.
- wb_en_i  in  1  one-cycle pulse: write back the current macroblock's MVD.
- wb_data_i  in  DATA_W  write-back MVD pair.
- err_o  out  1  sticky flag: out-of-range column or protocol violation.
- r_en_o  out  1  RF read enable.
- r_addr_o  out  ADDR_W  RF read address.
- r_data_i  in  DATA_W  RF read data; valid one cycle after r_en_o.
- w_en_o  out  1  RF write enable.
- w_addr_o  out  ADDR_W  RF write address.
- w_data_o  out  DATA_W  RF write data.

Behaviour:
- Clock is clk; reset is asynchronous, active-low on rst_n.
- Reset values: all outputs 0; FSM in IDLE; latched column x_q = 0, latched row y_q = 0.
- FSM states: IDLE, RD, CAP, HOLD.
- IDLE/HOLD, mb_start_i=1:
  - Latch x_q ← mb_x_i and y_q ← mb_y_i; clear top_vld_o.
  - If mb_x_i ≥ MB_X_TOTAL: set err_o, top_mvd_o ← 0, top_vld_o ← 1 next cycle, go to HOLD; no RF access.
  - Else if mb_y_i == 0: top_mvd_o ← 0, top_vld_o ← 1 next cycle, go to HOLD; no RF access.
  - Else: go to RD.
- RD: r_en_o=1, r_addr_o=x_q for exactly one cycle; busy_o=1; go to CAP.
- CAP: busy_o=1.
  - top_mvd_o ← r_data_i, or the forwarded value (see forwarding rule).
  - top_vld_o ← 1; go to HOLD.
- HOLD: outputs stable until the next mb_start_i.
- Latency: mb_start_i at cycle T → r_en_o at T+1 → top_vld_o at T+3. Unavailable or out-of-range cases: top_vld_o at T+1.
- mb_start_i while busy_o=1: ignored; set err_o; the fetch in flight completes normally.
- Write-back: wb_en_i at cycle T → w_en_o=1, w_addr_o=x_q, w_data_o=wb_data_i (all registered) at T+1, for one cycle.
  - Suppressed when x_q is out of range.
  - wb_en_i accepted in any state; it uses the x_q current at cycle T.
- Forwarding rule: if w_en_o=1 in the RD cycle and w_addr_o == r_addr_o, capture w_data_o instead of r_data_i in CAP. The RF's same-address read/write result is undefined, so the bypass is mandatory.
- wb_en_i and mb_start_i in the same cycle: the write uses the old x_q; the new x_q latches afterwards.
- Reset mid-operation: fetch and pending write are dropped; no RF enable is asserted after rst_n deasserts until new stimulus arrives.
- err_o is cleared only by reset.

Decomposition:
- Shared package `cabac_mvd_pkg`:
  - FMV_WIDTH- and MEM_TOP_DEPTH-derived widths (ADDR_W, DATA_W).
  - FSM state enum {IDLE, RD, CAP, HOLD}.
- One sub-module: `cabac_mvd_wb_reg`, the write-back register stage with address latch and forwarding compare.
- The RF wrapper is instantiated outside this block, by the parent.

Test Plan:
- Row 0, mb_x=5, mb_start → top_vld_o=1 at T+1, top_mvd_o=0, r_en_o never asserted.
- Write mb_x=3 with wb_data=0x2ABCD in row 0; then row 1, mb_x=3, mb_start → r_en_o at T+1 with r_addr_o=3; top_mvd_o=0x2ABCD, top_vld_o at T+3.
- Forwarding: wb_en_i (data 0x00F0F, x_q=7) timed so w_en_o coincides with the RD cycle for column 7 → top_mvd_o=0x00F0F regardless of r_data_i.
- mb_x=MB_X_TOTAL (120) → err_o=1, top_mvd_o=0, no r_en_o/w_en_o; subsequent wb_en_i also suppressed.
- mb_start_i during RD → ignored, err_o=1; the original fetch completes with correct data at T+3.
- rst_n low during CAP → all outputs 0 immediately; after release, no RF enable is asserted until the next mb_start_i or wb_en_i.

Source files
------------

// File: rtl/cabac_mvd_pkg.sv
// ============================================================================
// Module : cabac_mvd_pkg
// Brief  : Shared widths and FSM encoding for the CABAC top-row MVD buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cabac_mvd_pkg;

    localparam int CABAC_FMV_WIDTH     = 8;
    localparam int CABAC_MEM_TOP_DEPTH = 8;
    localparam int CABAC_ADDR_W        = CABAC_MEM_TOP_DEPTH;
    localparam int CABAC_DATA_W        = 2 * (CABAC_FMV_WIDTH + 1);
    localparam int CABAC_MB_X_TOTAL    = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        HOLD = 2'd3
    } mvd_state_t;

endpackage

`default_nettype wire

// File: rtl/cabac_mvd_wb_reg.sv
// ============================================================================
// Module : cabac_mvd_wb_reg
// Brief  : Write-back register stage with same-address read bypass capture.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cabac_mvd_wb_reg
    import cabac_mvd_pkg::*;
#(
    parameter int ADDR_W = CABAC_ADDR_W,
    parameter int DATA_W = CABAC_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic              wb_addr_ok_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              w_en_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [DATA_W-1:0] w_data_o,
    output logic              fwd_vld_o,
    output logic [DATA_W-1:0] fwd_data_o
);

    logic              r_w_en;
    logic [ADDR_W-1:0] r_w_addr;
    logic [DATA_W-1:0] r_w_data;
    logic              r_fwd_vld;
    logic [DATA_W-1:0] r_fwd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_en     <= 1'b0;
            r_w_addr   <= '0;
            r_w_data   <= '0;
            r_fwd_vld  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_w_en <= wb_en_i && wb_addr_ok_i;
            if (wb_en_i && wb_addr_ok_i) begin
                r_w_addr <= wb_addr_i;
                r_w_data <= wb_data_i;
            end
            // RF read result is undefined when it collides with the write
            r_fwd_vld <= rd_en_i && r_w_en && (r_w_addr == rd_addr_i);
            if (rd_en_i) begin
                r_fwd_data <= r_w_data;
            end
        end
    end

    assign w_en_o     = r_w_en;
    assign w_addr_o   = r_w_addr;
    assign w_data_o   = r_w_data;
    assign fwd_vld_o  = r_fwd_vld;
    assign fwd_data_o = r_fwd_data;

endmodule

`default_nettype wire

// File: rtl/cabac_mvd_top_ctrl.sv
// ============================================================================
// Module : cabac_mvd_top_ctrl
// Brief  : Top-row MVD line-buffer sequencer: neighbour fetch and write-back.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cabac_mvd_top_ctrl
    import cabac_mvd_pkg::*;
#(
    parameter int ADDR_W     = CABAC_ADDR_W,
    parameter int DATA_W     = CABAC_DATA_W,
    parameter int MB_X_TOTAL = CABAC_MB_X_TOTAL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mb_start_i,
    input  logic [ADDR_W-1:0] mb_x_i,
    input  logic [7:0]        mb_y_i,
    output logic              top_vld_o,
    output logic [DATA_W-1:0] top_mvd_o,
    output logic              busy_o,
    input  logic              wb_en_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              err_o,
    output logic              r_en_o,
    output logic [ADDR_W-1:0] r_addr_o,
    input  logic [DATA_W-1:0] r_data_i,
    output logic              w_en_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [DATA_W-1:0] w_data_o
);

    localparam logic [ADDR_W-1:0] c_x_total = ADDR_W'(MB_X_TOTAL);

    mvd_state_t        r_state;
    mvd_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_x;
    logic              r_vld;
    logic [DATA_W-1:0] r_mvd;
    logic              r_err;
    logic              w_busy;
    logic              w_rd;
    logic              w_accept;
    logic              w_x_oob;
    logic              w_x_q_ok;
    logic              w_fwd_vld;
    logic [DATA_W-1:0] w_fwd_data;

    assign w_accept = (r_state == IDLE) || (r_state == HOLD);
    assign w_x_oob  = (mb_x_i >= c_x_total);
    assign w_x_q_ok = (r_x < c_x_total);

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_rd        = 1'b0;
        case (r_state)
            IDLE, HOLD: begin
                if (mb_start_i) begin
                    w_state_nxt = (w_x_oob || (mb_y_i == 8'd0)) ? HOLD : RD;
                end
            end
            RD: begin
                w_rd        = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = CAP;
            end
            CAP: begin
                w_busy      = 1'b1;
                w_state_nxt = HOLD;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_vld   <= 1'b0;
            r_mvd   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (mb_start_i) begin
                if (w_accept) begin
                    r_x   <= mb_x_i;
                    r_vld <= 1'b0;
                    // Unavailable neighbours resolve immediately to a zero MVD
                    if (w_x_oob) begin
                        r_err <= 1'b1;
                        r_mvd <= '0;
                        r_vld <= 1'b1;
                    end else if (mb_y_i == 8'd0) begin
                        r_mvd <= '0;
                        r_vld <= 1'b1;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == CAP) begin
                r_mvd <= w_fwd_vld ? w_fwd_data : r_data_i;
                r_vld <= 1'b1;
            end
        end
    end

    cabac_mvd_wb_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wb_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_en_i      (wb_en_i),
        .wb_data_i    (wb_data_i),
        .wb_addr_i    (r_x),
        .wb_addr_ok_i (w_x_q_ok),
        .rd_en_i      (w_rd),
        .rd_addr_i    (r_x),
        .w_en_o       (w_en_o),
        .w_addr_o     (w_addr_o),
        .w_data_o     (w_data_o),
        .fwd_vld_o    (w_fwd_vld),
        .fwd_data_o   (w_fwd_data)
    );

    assign top_vld_o = r_vld;
    assign top_mvd_o = r_mvd;
    assign err_o     = r_err;
    assign busy_o    = w_busy;
    assign r_en_o    = w_rd;
    assign r_addr_o  = r_x;

endmodule

`default_nettype wire
